// File: rtl/cam_req_queue_pkg.sv
// Shared CAM types: key/value widths plus the request and response records
// that the request queue carries between the host and the CAM.
package cam_types;

  localparam int KEY_W = 16;
  localparam int VAL_W = 16;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [VAL_W-1:0] val_t;

  typedef struct packed {
    logic write;
    key_t key;
    val_t val;
  } cam_req_t;

  typedef struct packed {
    logic hit;
    val_t val;
  } cam_resp_t;

  // A miss always reports a zero value, whatever the CAM drives on its data bus.
  function automatic cam_resp_t make_resp(input logic hit, input val_t val);
    cam_resp_t r;
    r.hit = hit;
    r.val = hit ? val : '0;
    return r;
  endfunction

endpackage

// File: rtl/cam_req_queue_if.sv
// Host-side request/response handshakes and CAM-side strobes of the request queue.
// The slave modport is the queue's view; master is the host/CAM environment.
interface cam_req_queue_if;
  import cam_types::*;

  logic req_valid_i;
  logic req_ready_o;
  logic req_write_i;
  key_t req_key_i;
  val_t req_val_i;

  logic resp_valid_o;
  logic resp_ready_i;
  logic resp_hit_o;
  val_t resp_val_o;

  logic cam_read_o;
  logic cam_write_o;
  key_t cam_key_o;
  val_t cam_val_o;
  logic cam_valid_i;
  val_t cam_val_i;

  modport slave (
    input  req_valid_i, req_write_i, req_key_i, req_val_i,
    input  resp_ready_i, cam_valid_i, cam_val_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_val_o,
    output cam_read_o, cam_write_o, cam_key_o, cam_val_o
  );

  modport master (
    output req_valid_i, req_write_i, req_key_i, req_val_i,
    output resp_ready_i, cam_valid_i, cam_val_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_val_o,
    input  cam_read_o, cam_write_o, cam_key_o, cam_val_o
  );

endinterface

// File: rtl/cam_req_fifo.sv
// DEPTH-entry request FIFO (DEPTH a power of two, >= 2). full/empty come
// from the registered count only, so a same-cycle pop never frees a push.
module cam_req_fifo
  import cam_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  cam_req_t din,
  input  logic     pop,
  output cam_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  cam_req_t         mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after a push fills it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cam_req_queue.sv
// CAM request front-end: buffers host requests, issues one CAM strobe per
// cycle in strict order, and holds read results in a one-entry response slot.
module cam_req_queue
  import cam_types::*;
#(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  cam_req_queue_if.slave  bus
);

  cam_req_t  din;
  cam_req_t  head;
  logic      full;
  logic      empty;
  logic      issue;
  logic      slot_free;
  logic      cam_read;
  logic      cam_write;
  key_t      cam_key;
  val_t      cam_val;
  logic      resp_valid;
  cam_resp_t resp_q;

  assign din.write = bus.req_write_i;
  assign din.key   = bus.req_key_i;
  assign din.val   = bus.req_val_i;

  cam_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid_i),
    .din   (din),
    .pop   (issue),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign slot_free = ~resp_valid | bus.resp_ready_i;

  // Writes ignore the response slot; a read at the head waits for it.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue     = 1'b0;
    cam_read  = 1'b0;
    cam_write = 1'b0;
    cam_key   = '0;
    cam_val   = '0;
    if (!rst && !empty && (head.write || slot_free)) begin
      issue     = 1'b1;
      cam_read  = ~head.write;
      cam_write = head.write;
      cam_key   = head.key;
      cam_val   = head.val;
    end
  end

  // A new read result replaces a response being dequeued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_q     <= '0;
    end else if (cam_read) begin
      resp_valid <= 1'b1;
      resp_q     <= make_resp(bus.cam_valid_i, bus.cam_val_i);
    end else if (bus.resp_ready_i) begin
      resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o  = ~full;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_hit_o   = resp_q.hit;
  assign bus.resp_val_o   = resp_q.val;
  assign bus.cam_read_o   = cam_read;
  assign bus.cam_write_o  = cam_write;
  assign bus.cam_key_o    = cam_key;
  assign bus.cam_val_o    = cam_val;

endmodule

// File: doc/cam_req_queue.md
Name: cam_req_queue

Overview:
- Request front-end that sits directly upstream of the CAM (controller plus datapath).
- Accepts read/write requests from a host over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one operation per cycle to the CAM as single-cycle read/write strobes.
- Captures read results (hit flag and value) into a one-entry response register with its own valid/ready handshake.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- Key and value widths come from the cam_types key_t/val_t typedefs, not from parameters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  1  host request valid
- req_ready_o  out  1  FIFO can accept a request
- req_write_i  in  1  1 = write, 0 = read
- req_key_i  in  key_t  request key
- req_val_i  in  val_t  write data; ignored for reads
- resp_valid_o  out  1  read response available
- resp_ready_i  in  1  host consumes response
- resp_hit_o  out  1  read hit
- resp_val_o  out  val_t  read data; 0 on miss
- cam_read_o  out  1  CAM read strobe, one cycle per issued read
- cam_write_o  out  1  CAM write strobe, one cycle per issued write
- cam_key_o  out  key_t  key for the issued operation
- cam_val_o  out  val_t  write data for the issued operation
- cam_valid_i  in  1  CAM hit indication; combinational in the issue cycle
- cam_val_i  in  val_t  CAM read data; combinational in the issue cycle

Behaviour:
- Reset values, synchronous on rst=1:
  - FIFO count, rd_ptr and wr_ptr = 0.
  - resp_valid_o, resp_hit_o, resp_val_o = 0.
  - req_ready_o = 1 from the first cycle after reset.
- Reset while requests are queued or a response is pending flushes everything; no strobe is issued in the reset cycle.
- Push:
  - Occurs when req_valid_i & req_ready_o.
  - req_ready_o = (count != DEPTH) and depends only on registered state, never on pop.
  - When full, a same-cycle pop does not allow a push.
  - Entry = {write, key, val}; wr_ptr increments mod DEPTH.
- Response slot is free when !resp_valid_o | resp_ready_i.
- Issue (pop):
  - Condition: count != 0 and (head is a write, or response slot is free).
  - There is no bypass: a request pushed in cycle N is issued in cycle N+1 at the earliest.
  - During the issue cycle:
    - cam_read_o or cam_write_o = 1, selected by the head's op.
    - cam_key_o / cam_val_o = head fields.
    - rd_ptr increments mod DEPTH.
  - Both strobes are never high together. Both are 0 when nothing issues.
  - cam_key_o / cam_val_o are don't-care when both strobes are 0 but must not be X.
- Read response:
  - Registered at the end of the issue cycle: resp_valid_o <= 1, resp_hit_o <= cam_valid_i, resp_val_o <= cam_valid_i ? cam_val_i : 0.
  - Latency from accepted read to resp_valid_o is 2 cycles minimum.
- Response dequeue:
  - When resp_valid_o & resp_ready_i and no new read issues, resp_valid_o <= 0.
  - Dequeue plus a new read issue in the same cycle loads the new result (throughput 1/cycle).
  - Response fields are held stable while resp_valid_o & !resp_ready_i.
- Writes:
  - Never produce a response.
  - Issue even when the response slot is busy, so a write behind a stalled read is still blocked by FIFO order. Strict in-order issue; no reordering.
- Count: count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap at DEPTH.
  - Occupancy never exceeds DEPTH and never goes below 0.
- Ordering: a write followed by a read of the same key is issued in consecutive cycles at the earliest, so the read observes the written value (the CAM updates at the write-cycle edge).

Decomposition:
- Package cam_types (shared) gains:
  - cam_req_t struct {logic write; key_t key; val_t val;}
  - cam_resp_t struct {logic hit; val_t val;}
- One sub-module, cam_req_fifo: parameterised DEPTH storage of cam_req_t with push/pop/full/empty.
- Issue and response logic live in the top level.

Test Plan:
- Reset then idle: req_ready_o=1, resp_valid_o=0, both cam strobes 0 for 10 cycles.
- Write key 0x0011 val 0xBEEF, then read key 0x0011 back-to-back (CAM model hits):
  - cam_write_o in cycle 1, cam_read_o in cycle 2.
  - Response hit=1, val=0xBEEF valid in cycle 3.
- Read of absent key 0x0042 (cam_valid_i=0): response hit=0, val=0.
- Hold resp_ready_i=0 and push 5 reads with DEPTH=4:
  - First read issues; FIFO then fills with 4 entries and req_ready_o=0.
  - Release resp_ready_i: one response per cycle, keys in order.
- Full FIFO with req_valid_i held high during a pop cycle: no push that cycle; push accepted the next cycle; count stays ≤4.
- Assert rst with 3 queued requests and a pending response: the next cycle shows count 0, resp_valid_o=0, no strobes, and none of the flushed requests ever issue.
